// File: rtl/ps2_arrow_decoder_if.sv
// Bundle of the PS/2 pin pair and the decoded key/scan outputs of ps2_arrow_decoder.
// The master side drives the PS/2 lines and observes the decoded results.
interface ps2_arrow_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] key;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  key, scan_code, scan_valid, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output key, scan_code, scan_valid, frame_err
    );
endinterface

// File: rtl/ps2_arrow_decoder.sv
// PS/2 set-2 receiver that turns arrow-key make/break sequences into a held-key vector {right,left,down,up}.
// Define PS2_WASD_EN to let the W/A/S/D letter keys drive the same bits alongside the arrows.
module ps2_arrow_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input logic                 pclk,
    input logic                 rst,
    ps2_arrow_decoder_if.slave  bus
);
    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t      state, state_next;
    logic        clk_s1, clk_s2, data_s1, data_s2;
    logic        filt_clk, strobe;
    logic [FILT_W-1:0] filt_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        parity_bit;
    logic        ext, brk;
    logic [3:0]  arrow_key;
    logic [7:0]  scan_code_r;
    logic        scan_valid_r, frame_err_r;
    logic        timeout_hit, frame_ok, frame_bad;

    // Synchronize both lines, then require FILTER_LEN agreeing samples before the filtered clock
    // flips; the strobe fires on the cycle the filtered clock falls.
    always_ff @(posedge pclk) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            strobe   <= 1'b0;
        end else begin
            clk_s1  <= bus.ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= bus.ps2_data;
            data_s2 <= data_s1;
            strobe  <= 1'b0;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
                filt_cnt <= '0;
                filt_clk <= clk_s2;
                strobe   <= filt_clk & ~clk_s2;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (timeout_hit) begin
            state_next = IDLE;
        end else if (strobe) begin
            case (state)
                IDLE:    if (!data_s2) state_next = DATA;
                DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // A strobe and a timeout can never coincide, which keeps scan_valid and frame_err exclusive.
    always_comb begin
        timeout_hit = (state != IDLE) && !strobe && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
        frame_ok    = (state == STOP) && strobe && data_s2 && (^{parity_bit, shift_reg});
        frame_bad   = ((state == STOP) && strobe && !(data_s2 && (^{parity_bit, shift_reg})))
                      || timeout_hit;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            to_cnt     <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            if (state == IDLE || strobe || timeout_hit) to_cnt <= '0;
            else                                        to_cnt <= to_cnt + 1'b1;
            if (strobe) begin
                case (state)
                    IDLE:    bit_cnt <= '0;
                    DATA: begin
                        shift_reg <= {data_s2, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                    PARITY:  parity_bit <= data_s2;
                    default: ;
                endcase
            end
        end
    end

`ifdef PS2_WASD_EN
    logic [3:0] letter_key;
`endif

    // Decode happens on the same edge that raises scan_valid so key and scan_code appear together.
    always_ff @(posedge pclk) begin
        if (rst) begin
            scan_code_r  <= 8'h00;
            scan_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            ext          <= 1'b0;
            brk          <= 1'b0;
            arrow_key    <= 4'b0000;
`ifdef PS2_WASD_EN
            letter_key   <= 4'b0000;
`endif
        end else begin
            scan_valid_r <= frame_ok;
            frame_err_r  <= frame_bad;
            if (frame_bad) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (frame_ok) begin
                scan_code_r <= shift_reg;
                case (shift_reg)
                    8'hE0: ext <= 1'b1;
                    8'hF0: brk <= 1'b1;
                    8'h00, 8'hFF, 8'hAA: begin
                        arrow_key <= 4'b0000;
`ifdef PS2_WASD_EN
                        letter_key <= 4'b0000;
`endif
                        ext <= 1'b0;
                        brk <= 1'b0;
                    end
                    default: begin
                        if (ext) begin
                            case (shift_reg)
                                8'h74:   arrow_key[3] <= ~brk;
                                8'h6B:   arrow_key[2] <= ~brk;
                                8'h72:   arrow_key[1] <= ~brk;
                                8'h75:   arrow_key[0] <= ~brk;
                                default: ;
                            endcase
                        end
`ifdef PS2_WASD_EN
                        else begin
                            case (shift_reg)
                                8'h23:   letter_key[3] <= ~brk;
                                8'h1C:   letter_key[2] <= ~brk;
                                8'h1B:   letter_key[1] <= ~brk;
                                8'h1D:   letter_key[0] <= ~brk;
                                default: ;
                            endcase
                        end
`endif
                        ext <= 1'b0;
                        brk <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PS2_WASD_EN
    assign bus.key = arrow_key | letter_key;
`else
    assign bus.key = arrow_key;
`endif
    assign bus.scan_code  = scan_code_r;
    assign bus.scan_valid = scan_valid_r;
    assign bus.frame_err  = frame_err_r;
endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Scoreboard bench for ps2_arrow_decoder: directed PS/2 frames push expected events,
// a monitor pops and compares whenever scan_valid or frame_err pulses.
module tb_ps2_arrow_decoder;
    localparam int HALF    = 30;
    localparam int TIMEOUT = 2000;

    typedef struct packed {
        logic       is_err;
        logic [7:0] code;
        logic [3:0] key;
    } event_t;

    logic   pclk = 1'b0;
    logic   rst  = 1'b1;
    event_t exp_q[$];
    int     compared   = 0;
    int     mismatched = 0;

    ps2_arrow_decoder_if bus ();

    ps2_arrow_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.ps2_data = b;
        wait_cycles(HALF);
        bus.ps2_clk = 1'b0;
        wait_cycles(HALF);
        bus.ps2_clk = 1'b1;
    endtask

    // Sends a full frame; bad_parity flips the parity bit.
    task automatic send_frame(input logic [7:0] code, input logic bad_parity);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit((~^code) ^ bad_parity);
        send_bit(1'b1);
        bus.ps2_data = 1'b1;
        wait_cycles(3 * HALF);
    endtask

    task automatic apply_stimulus(input logic [7:0] code, input logic [3:0] key_after);
        exp_q.push_back('{is_err: 1'b0, code: code, key: key_after});
        send_frame(code, 1'b0);
    endtask

    task automatic expect_error(input logic [7:0] last_code, input logic [3:0] key_now);
        exp_q.push_back('{is_err: 1'b1, code: last_code, key: key_now});
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge pclk) begin
        if (!rst && (bus.scan_valid || bus.frame_err)) begin
            check_output("valid_err_exclusive", {31'd0, bus.scan_valid & bus.frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                check_output("unexpected_pulse", {30'd0, bus.scan_valid, bus.frame_err}, 32'd0);
            end else begin
                event_t e;
                e = exp_q.pop_front();
                check_output("event_is_err", {31'd0, bus.frame_err}, {31'd0, e.is_err});
                check_output("scan_code",    {24'd0, bus.scan_code}, {24'd0, e.code});
                check_output("key",          {28'd0, bus.key},       {28'd0, e.key});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        wait_cycles(5);
        rst = 1'b0;
        wait_cycles(2);
        check_output("reset_key",        {28'd0, bus.key},        32'd0);
        check_output("reset_scan_code",  {24'd0, bus.scan_code},  32'd0);
        check_output("reset_scan_valid", {31'd0, bus.scan_valid}, 32'd0);
        check_output("reset_frame_err",  {31'd0, bus.frame_err},  32'd0);

        apply_stimulus(8'hE0, 4'b0000);
        apply_stimulus(8'h74, 4'b1000);
        apply_stimulus(8'hE0, 4'b1000);
        apply_stimulus(8'hF0, 4'b1000);
        apply_stimulus(8'h74, 4'b0000);

        apply_stimulus(8'hE0, 4'b0000);
        apply_stimulus(8'h75, 4'b0001);
        apply_stimulus(8'hE0, 4'b0001);
        apply_stimulus(8'h6B, 4'b0101);
        apply_stimulus(8'hE0, 4'b0101);
        apply_stimulus(8'hF0, 4'b0101);
        apply_stimulus(8'h75, 4'b0100);

`ifdef PS2_WASD_EN
        apply_stimulus(8'h1D, 4'b0101);
        apply_stimulus(8'hE0, 4'b0101);
        apply_stimulus(8'h75, 4'b0101);
        apply_stimulus(8'hF0, 4'b0101);
        apply_stimulus(8'h1D, 4'b0101);
        apply_stimulus(8'hE0, 4'b0101);
        apply_stimulus(8'hF0, 4'b0101);
        apply_stimulus(8'h75, 4'b0100);
`endif

        expect_error(8'h75, 4'b0100);
        send_frame(8'h74, 1'b1);
        check_output("bad_parity_key", {28'd0, bus.key}, 32'd4);

        // Partial frame then a silent clock long enough to trip the timeout.
        expect_error(8'h75, 4'b0100);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus.ps2_data = 1'b1;
        wait_cycles(TIMEOUT + TIMEOUT / 2);
        apply_stimulus(8'h1C, 4'b0100);

        // Short clock glitch while idle must not start a frame.
        bus.ps2_clk = 1'b0;
        wait_cycles(3);
        bus.ps2_clk = 1'b1;
        wait_cycles(4 * HALF);

        apply_stimulus(8'hE0, 4'b0100);
        apply_stimulus(8'h74, 4'b1100);
        apply_stimulus(8'hE0, 4'b1100);
        apply_stimulus(8'h72, 4'b1110);
        apply_stimulus(8'hE0, 4'b1110);
        apply_stimulus(8'h75, 4'b1111);
        apply_stimulus(8'hE0, 4'b1111);
        apply_stimulus(8'h75, 4'b1111);
        apply_stimulus(8'hFF, 4'b0000);

        apply_stimulus(8'hE0, 4'b0000);
        apply_stimulus(8'h74, 4'b1000);
        apply_stimulus(8'hAA, 4'b0000);

        apply_stimulus(8'hE0, 4'b0000);
        apply_stimulus(8'h6B, 4'b0100);

        // Reset in the middle of a frame drops it and clears the held keys.
        apply_stimulus(8'hE0, 4'b0100);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        bus.ps2_data = 1'b1;
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        wait_cycles(2);
        check_output("mid_reset_key",  {28'd0, bus.key},       32'd0);
        check_output("mid_reset_code", {24'd0, bus.scan_code}, 32'd0);
        wait_cycles(4 * HALF);
        apply_stimulus(8'h74, 4'b0000);
        apply_stimulus(8'hE0, 4'b0000);
        apply_stimulus(8'h6B, 4'b0100);

        wait_cycles(200);
        check_output("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ps2_arrow_decoder.md
Name: ps2_arrow_decoder

Overview:
- Receives PS/2 keyboard frames on the board's PS/2 lines in the 65 MHz pixel-clock domain.
- Decodes set-2 make/break sequences for the four arrow keys into a held-key vector.
- The vector is bit-compatible with the debounced button bus that feeds car_ctl, so car_ctl can take buttons OR keyboard.
- Sits upstream of car_ctl, alongside the button debouncers.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized ps2_clk samples needed before the filtered clock changes.
- TIMEOUT_CYCLES, 65000: pclk cycles without a ps2_clk falling edge before a partial frame is abandoned (1 ms at 65 MHz).

Ports:
- pclk  in  1  system clock (65 MHz domain).
- rst  in  1  synchronous reset, active high; one clock, reset is synchronous and active-high.
- ps2_clk  in  1  raw PS/2 clock (asynchronous).
- ps2_data  in  1  raw PS/2 data (asynchronous).
- key  out  4  held state {right, left, down, up}; 1 = pressed.
- scan_code  out  8  last correctly received byte.
- scan_valid  out  1  one-cycle pulse when scan_code updates.
- frame_err  out  1  one-cycle pulse on parity, stop-bit or timeout error.

Behaviour:
- Reset: key=4'b0000, scan_code=8'h00, scan_valid=0, frame_err=0, FSM=IDLE, bit counter=0, ext/brk flags=0, filter state=1, timeout counter=0.
- Input conditioning:
  - Two-flop synchronizer on both lines.
  - The synchronized clock passes the FILTER_LEN glitch filter.
  - A falling edge (filtered 1->0) produces a one-cycle sample strobe.
  - Data is taken from the synchronized ps2_data on that strobe.
- Frame FSM (advances only on sample strobes, except timeout):
  - IDLE: data=0 -> DATA, bit counter=0. Data=1 (false start) -> stay IDLE, no error.
  - DATA: shift data in LSB first. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: valid requires data=1 and odd parity over 8 data bits + parity bit.
    - Valid: scan_code<=byte, scan_valid=1 on the next pclk edge, then decode.
    - Invalid: frame_err=1, byte discarded, ext/brk cleared.
    - Either way -> IDLE.
- Timeout: in DATA/PARITY/STOP, the counter increments each pclk and clears on every strobe. When it reaches TIMEOUT_CYCLES-1: frame_err=1, FSM -> IDLE, partial byte discarded, ext/brk cleared. The counter is held at 0 in IDLE.
- Decode, same cycle as scan_valid (key updates visible together with scan_valid):
  - 8'hE0: ext<=1.
  - 8'hF0: brk<=1.
  - 8'h00 or 8'hFF (keyboard overrun/error): key<=0, flags cleared.
  - 8'hAA (self-test pass): key<=0, flags cleared.
  - Other byte with ext=1: 74->key[3], 6B->key[2], 72->key[1], 75->key[0]. The bit is set to ~brk; flags are then cleared.
  - Other byte with ext=0: no key change, flags cleared (unless the optional feature applies).
- Repeated make codes (typematic) leave key unchanged. Several keys may be held at once; bits are independent.
- Latency from the stop-bit falling edge to key/scan_valid: 1 pclk after the strobe. The strobe itself is 2 sync + FILTER_LEN cycles after the pin edge.
- rst mid-frame: the partial frame is lost, key cleared. The first full frame after rst deasserts is received normally.
- scan_valid and frame_err are never asserted in the same cycle.

Optional Feature:
- PS2_WASD_EN defined: non-extended W(1D), A(1C), S(1B), D(23) also drive key[0], key[2], key[1], key[3] respectively, with the same ~brk rule.
  - Each key bit is the OR of two internal held bits (arrow and letter).
  - Releasing one source does not clear a bit still held by the other source.
- Undefined: letter codes only clear flags, and each key bit reflects only its arrow.

Test Plan:
- Frames E0,74 (10 µs clock half-period, correct parity) -> key=4'b1000, scan_code=74, two scan_valid pulses. Then E0,F0,74 -> key=4'b0000.
- E0,75 then E0,6B -> key=4'b0101. Then E0,F0,75 -> key=4'b0100.
- Frame 74 with wrong parity bit -> frame_err one pulse, no scan_valid, key unchanged, scan_code unchanged.
- Start bit plus 4 data bits, then the clock stops for 1.5 ms -> frame_err after TIMEOUT_CYCLES. A following full frame 8'h1C is received correctly.
- Glitch: a 3-cycle low pulse on ps2_clk while idle -> no FSM change. Byte FF while key=4'b1111 -> key=4'b0000.
- With PS2_WASD_EN: 1D plus E0,75 -> key[0]=1. Then F0,1D -> key[0] stays 1. Then E0,F0,75 -> key[0]=0.
